// File: rtl/ibufds_rx_bank.sv
// N-lane differential receiver: per-lane decode, 2-flop sync, post-enable settle
// window, glitch filter on the qualified level, and sticky invalid-pair error.
module ibufds_rx_bank #(
  parameter int   N           = 4,
  parameter int   SETTLE      = 16,
  parameter int   FILTER      = 3,
  parameter logic DISABLE_VAL = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] in_p,
  input  logic [N-1:0] in_n,
  input  logic [N-1:0] ibufdisable,
  input  logic [N-1:0] err_clear,
  output logic [N-1:0] out,
  output logic [N-1:0] valid,
  output logic [N-1:0] err
);

  localparam int SW = $clog2(SETTLE + 1);
  localparam int FW = $clog2(FILTER + 1);
  localparam logic [SW-1:0] SETTLE_TC = SW'(SETTLE);
  localparam logic [FW-1:0] FILTER_TC = FW'(FILTER - 1);

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic          lvl;
    logic [SW-1:0] scnt;
    logic [SW-1:0] scnt_nxt;
    logic [FW-1:0] fcnt;
    logic          lane_out;
    logic          lane_err;
    logic          inv;
    logic          dec;
    logic          qual;

    // Stage-2 pair {p,n}; an equal pair carries no information, so the
    // last good level is reused.
    assign inv      = (sync2[1] == sync2[0]);
    assign dec      = inv ? lvl : sync2[1];
    assign qual     = (scnt == SETTLE_TC);
    assign scnt_nxt = qual ? scnt : scnt + 1'b1;

    always_ff @(posedge clk) begin
      if (reset) begin
        sync1    <= 2'b00;
        sync2    <= 2'b00;
        lvl      <= DISABLE_VAL;
        scnt     <= '0;
        fcnt     <= '0;
        lane_out <= DISABLE_VAL;
        lane_err <= 1'b0;
      end else begin
        sync1 <= {in_p[i], in_n[i]};
        sync2 <= sync1;
        lvl   <= dec;

        if (qual && inv) begin
          lane_err <= 1'b1;
        end else if (err_clear[i]) begin
          lane_err <= 1'b0;
        end

        if (ibufdisable[i]) begin
          scnt     <= '0;
          fcnt     <= '0;
          lane_out <= DISABLE_VAL;
        end else if (!qual) begin
          // Qualification edge loads the level directly, bypassing the filter.
          scnt     <= scnt_nxt;
          fcnt     <= '0;
          lane_out <= (scnt_nxt == SETTLE_TC) ? dec : DISABLE_VAL;
        end else if (!inv) begin
          if (dec == lane_out) begin
            fcnt <= '0;
          end else if (fcnt == FILTER_TC) begin
            lane_out <= dec;
            fcnt     <= '0;
          end else begin
            fcnt <= fcnt + 1'b1;
          end
        end
      end
    end

    assign out[i]   = lane_out;
    assign valid[i] = qual;
    assign err[i]   = lane_err;
  end

endmodule

// File: tb/tb_ibufds_rx_bank.sv
// Self-checking bench for ibufds_rx_bank: directed scenarios plus a randomized
// run compared against a cycle model built from sample history and run lengths.
module tb_ibufds_rx_bank;
  localparam int   N      = 4;
  localparam int   SETTLE = 16;
  localparam int   FILTER = 3;
  localparam logic DV     = 1'b0;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] in_p, in_n, ibufdisable, err_clear;
  logic [N-1:0] out, valid, err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [1:0]   hist [N][$];
  logic         held [N];
  int           en_cycles [N];
  int           run [N];
  logic [N-1:0] m_out, m_valid, m_err;

  ibufds_rx_bank #(.N(N), .SETTLE(SETTLE), .FILTER(FILTER), .DISABLE_VAL(DV)) dut (
    .clk(clk), .reset(reset), .in_p(in_p), .in_n(in_n),
    .ibufdisable(ibufdisable), .err_clear(err_clear),
    .out(out), .valid(valid), .err(err)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    for (int c = 0; c < N; c++) begin
      if (reset) begin
        hist[c] = '{2'b00, 2'b00};
        held[c] = DV;
        en_cycles[c] = 0;
        run[c] = 0;
        m_out[c] = DV;
        m_err[c] = 1'b0;
      end else begin
        logic [1:0] s;
        logic good, qualified;
        s = hist[c][0];
        void'(hist[c].pop_front());
        hist[c].push_back({in_p[c], in_n[c]});
        good = (s[1] != s[0]);
        qualified = (en_cycles[c] >= SETTLE);
        if (good) held[c] = s[1];
        if (qualified && !good) m_err[c] = 1'b1;
        else if (err_clear[c]) m_err[c] = 1'b0;
        if (ibufdisable[c]) begin
          en_cycles[c] = 0;
          run[c] = 0;
          m_out[c] = DV;
        end else if (!qualified) begin
          en_cycles[c] = en_cycles[c] + 1;
          run[c] = 0;
          m_out[c] = (en_cycles[c] >= SETTLE) ? held[c] : DV;
        end else if (good) begin
          if (held[c] == m_out[c]) run[c] = 0;
          else begin
            run[c] = run[c] + 1;
            if (run[c] >= FILTER) begin
              m_out[c] = held[c];
              run[c] = 0;
            end
          end
        end
      end
      m_valid[c] = (en_cycles[c] >= SETTLE);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_p = '0; in_n = '0; ibufdisable = '0; err_clear = '0;
    tick(); tick();
    n_checks++;
    if ({out, valid, err} !== {{N{DV}}, {N{1'b0}}, {N{1'b0}}}) begin
      n_fail++;
      $display("FAIL reset_state: got out=%b valid=%b err=%b required out=%b valid=0 err=0", out, valid, err, {N{DV}});
    end
  endtask

  task automatic test_settle();
    logic bad;
    in_p = '1; in_n = '0;
    tick();
    reset = 1'b0;
    bad = 1'b0;
    for (int c = 1; c <= SETTLE; c++) begin
      tick();
      if (c < SETTLE && (valid !== '0 || out !== '0)) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL settle_early: valid/out rose before cycle %0d", SETTLE);
    end
    n_checks++;
    if (valid !== '1 || out !== '1) begin
      n_fail++;
      $display("FAIL settle_qualify: got valid=%b out=%b required valid=1111 out=1111", valid, out);
    end
  endtask

  task automatic test_latency();
    int lat;
    logic others_bad;
    lat = -1;
    others_bad = 1'b0;
    in_p[0] = 1'b0; in_n[0] = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (lat < 0 && out[0] === 1'b0) lat = t;
      if (out[3:1] !== 3'b111) others_bad = 1'b1;
    end
    n_checks++;
    if (lat != 2 + FILTER) begin
      n_fail++;
      $display("FAIL edge_latency: got %0d cycles required %0d", lat, 2 + FILTER);
    end
    n_checks++;
    if (others_bad) begin
      n_fail++;
      $display("FAIL edge_isolation: other lanes moved, out=%b", out);
    end
  endtask

  task automatic test_glitch();
    logic [11:0] obs;
    logic bad;
    in_p[1] = 1'b0; in_n[1] = 1'b1;
    for (int t = 0; t < 8; t++) tick();
    n_checks++;
    if (out[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_setup: got out1=%b required 0", out[1]);
    end
    bad = 1'b0;
    for (int w = 1; w <= 2; w++) begin
      in_p[1] = 1'b1; in_n[1] = 1'b0;
      for (int t = 0; t < w; t++) begin tick(); if (out[1] !== 1'b0) bad = 1'b1; end
      in_p[1] = 1'b0; in_n[1] = 1'b1;
      for (int t = 0; t < 10; t++) begin tick(); if (out[1] !== 1'b0) bad = 1'b1; end
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL glitch_reject: short pulse reached out1");
    end
    in_p[1] = 1'b1; in_n[1] = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      obs[t-1] = out[1];
      if (t == 3) begin in_p[1] = 1'b0; in_n[1] = 1'b1; end
    end
    n_checks++;
    if (obs !== 12'b0000_0111_0000) begin
      n_fail++;
      $display("FAIL glitch_pass3: got %b required %b", obs, 12'b0000_0111_0000);
    end
  endtask

  task automatic test_disable();
    int cnt;
    ibufdisable[2] = 1'b1;
    tick();
    ibufdisable[2] = 1'b0;
    for (int t = 0; t < 10; t++) tick();
    n_checks++;
    if (valid[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL disable_midsettle: got valid2=%b required 0", valid[2]);
    end
    ibufdisable[2] = 1'b1;
    tick();
    n_checks++;
    if (valid[2] !== 1'b0 || out[2] !== DV || valid[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL disable_abort: got valid=%b out=%b required valid2=0 out2=%b valid3=1", valid, out, DV);
    end
    ibufdisable[2] = 1'b0;
    cnt = -1;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (cnt < 0 && valid[2] === 1'b1) cnt = t;
    end
    n_checks++;
    if (cnt != SETTLE) begin
      n_fail++;
      $display("FAIL disable_resettle: got %0d cycles required %0d", cnt, SETTLE);
    end
  endtask

  task automatic test_invalid();
    logic out_bad;
    out_bad = 1'b0;
    in_p[3] = 1'b1; in_n[3] = 1'b1;
    tick(); if (out[3] !== 1'b1) out_bad = 1'b1;
    tick(); if (out[3] !== 1'b1) out_bad = 1'b1;
    n_checks++;
    if (err[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL invalid_early: got err3=%b required 0", err[3]);
    end
    in_n[3] = 1'b0;
    tick();
    n_checks++;
    if (err[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL invalid_set: got err3=%b required 1", err[3]);
    end
    for (int t = 0; t < 5; t++) begin tick(); if (out[3] !== 1'b1) out_bad = 1'b1; end
    n_checks++;
    if (err[3] !== 1'b1 || out_bad) begin
      n_fail++;
      $display("FAIL invalid_hold: got err3=%b out_disturbed=%b required err3=1 out_disturbed=0", err[3], out_bad);
    end
    in_n[3] = 1'b1;
    for (int t = 0; t < 3; t++) tick();
    err_clear[3] = 1'b1; tick(); err_clear[3] = 1'b0;
    n_checks++;
    if (err[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_vs_set: got err3=%b required 1", err[3]);
    end
    in_n[3] = 1'b0;
    for (int t = 0; t < 4; t++) tick();
    err_clear[3] = 1'b1; tick(); err_clear[3] = 1'b0;
    n_checks++;
    if (err[3] !== 1'b0 || out[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL clear: got err3=%b out3=%b required err3=0 out3=1", err[3], out[3]);
    end
  endtask

  task automatic test_reset_mid();
    logic bad;
    in_p = '0; in_n = '0;
    for (int t = 0; t < 3; t++) tick();
    in_p = '1; in_n = '0;
    for (int t = 0; t < 4; t++) tick();
    n_checks++;
    if (err !== '1 || valid !== '1) begin
      n_fail++;
      $display("FAIL resetmid_setup: got err=%b valid=%b required 1111 1111", err, valid);
    end
    reset = 1'b1; tick(); reset = 1'b0;
    n_checks++;
    if ({out, valid, err} !== {{N{DV}}, {N{1'b0}}, {N{1'b0}}}) begin
      n_fail++;
      $display("FAIL resetmid_clear: got out=%b valid=%b err=%b required all 0", out, valid, err);
    end
    bad = 1'b0;
    for (int t = 1; t <= SETTLE; t++) begin
      tick();
      if (t < SETTLE && valid !== '0) bad = 1'b1;
    end
    n_checks++;
    if (bad || valid !== '1) begin
      n_fail++;
      $display("FAIL resetmid_resettle: got valid=%b early=%b required 1111 at cycle %0d", valid, bad, SETTLE);
    end
  endtask

  task automatic test_model_check();
    n_checks++;
    if ({out, valid, err} !== {m_out, m_valid, m_err}) begin
      n_fail++;
      $display("FAIL model_sync: got %b/%b/%b required %b/%b/%b", out, valid, err, m_out, m_valid, m_err);
    end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int t = 0; t < 3000; t++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(3) == 0) begin
          if ($urandom_range(7) == 0) begin
            in_p[c] = $urandom_range(1); in_n[c] = in_p[c];
          end else begin
            in_p[c] = $urandom_range(1); in_n[c] = ~in_p[c];
          end
        end
        if ($urandom_range(47) == 0) ibufdisable[c] = ~ibufdisable[c];
        err_clear[c] = ($urandom_range(7) == 0);
      end
      reset = ($urandom_range(699) == 0);
      tick();
      n_checks++;
      if ({out, valid, err} !== {m_out, m_valid, m_err}) begin
        n_fail++;
        errs++;
        if (errs <= 10)
          $display("FAIL random_cycle%0d: got out=%b valid=%b err=%b required out=%b valid=%b err=%b",
                   t, out, valid, err, m_out, m_valid, m_err);
      end
    end
    reset = 1'b0; ibufdisable = '0; err_clear = '0;
  endtask

  initial begin
    test_reset();
    test_settle();
    test_latency();
    test_glitch();
    test_disable();
    test_invalid();
    test_model_check();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
